// File: rtl/debug_regfile_access_ctrl_if.sv
// Debug request/response channel between debug_peripheral and debug_regfile_access_ctrl.
interface debug_regfile_access_ctrl_if;
   logic        i_Dbg_Req_Valid;
   logic        o_Dbg_Req_Ready;
   logic        i_Dbg_Req_Write;
   logic [4:0]  i_Dbg_Req_Addr;
   logic [31:0] i_Dbg_Req_Data;
   logic        o_Dbg_Rsp_Valid;
   logic [31:0] o_Dbg_Rsp_Data;
   logic        o_Dbg_Rsp_Error;

   modport slave (
      input  i_Dbg_Req_Valid,
      output o_Dbg_Req_Ready,
      input  i_Dbg_Req_Write,
      input  i_Dbg_Req_Addr,
      input  i_Dbg_Req_Data,
      output o_Dbg_Rsp_Valid,
      output o_Dbg_Rsp_Data,
      output o_Dbg_Rsp_Error
   );

   modport master (
      output i_Dbg_Req_Valid,
      input  o_Dbg_Req_Ready,
      output i_Dbg_Req_Write,
      output i_Dbg_Req_Addr,
      output i_Dbg_Req_Data,
      input  o_Dbg_Rsp_Valid,
      input  o_Dbg_Rsp_Data,
      input  o_Dbg_Rsp_Error
   );
endinterface

// File: rtl/debug_regfile_access_ctrl.sv
// Halts the CPU, waits for flush, then performs one debugger register-file read or write.
// Optional: DEBUG_REG_X0_GUARD_EN suppresses debug writes to register x0.
module debug_regfile_access_ctrl #(
   parameter int unsigned FLUSH_TIMEOUT_CYCLES = 1024
) (
   input  logic                         i_Clock,
   input  logic                         i_Reset,
   debug_regfile_access_ctrl_if.slave   dbg,
   input  logic                         i_Hold_Halt,
   output logic                         o_Halt_Request,
   input  logic                         i_Pipeline_Flushed,
   input  logic                         i_Cpu_Reg_Write_Enable,
   input  logic [4:0]                   i_Cpu_Reg_Write_Addr,
   input  logic [31:0]                  i_Cpu_Reg_Write_Data,
   input  logic [4:0]                   i_Cpu_Reg_Read_Addr,
   output logic                         o_Rf_Write_Enable,
   output logic [4:0]                   o_Rf_Write_Addr,
   output logic [31:0]                  o_Rf_Write_Data,
   output logic [4:0]                   o_Rf_Read_Addr,
   input  logic [31:0]                  i_Rf_Read_Data
);

   localparam int unsigned CNT_W  = $clog2(FLUSH_TIMEOUT_CYCLES);
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 32;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_HALT_WAIT = 3'd1;
   localparam logic [2:0] ST_ACCESS    = 3'd2;
   localparam logic [2:0] ST_READ_WAIT = 3'd3;
   localparam logic [2:0] ST_RESPOND   = 3'd4;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_TIMEOUT_CYCLES - 1);

   logic [2:0]        state_q,     state_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic              halt_q,      halt_d;
   logic              wr_q,        wr_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic [DATA_W-1:0] data_q,      data_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
   logic              rsp_err_q,   rsp_err_d;
   logic              dbg_owns_rf_c;
   logic              dbg_we_c;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         halt_q      <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         halt_q      <= halt_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Response fields are loaded on the edge into RESPOND, so they are valid for that one cycle only.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      halt_d      = halt_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      data_d      = data_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = '0;
      rsp_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            halt_d = halt_q & i_Hold_Halt;
            if (dbg.i_Dbg_Req_Valid) begin
               wr_d    = dbg.i_Dbg_Req_Write;
               addr_d  = dbg.i_Dbg_Req_Addr;
               data_d  = dbg.i_Dbg_Req_Data;
               cnt_d   = '0;
               halt_d  = 1'b1;
               state_d = ST_HALT_WAIT;
            end
         end
         ST_HALT_WAIT: begin
            if (i_Pipeline_Flushed) begin
               state_d = ST_ACCESS;
            end else if (cnt_q == CNT_LAST) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               state_d     = ST_RESPOND;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_ACCESS: begin
            if (wr_q) begin
               rsp_valid_d = 1'b1;
               state_d     = ST_RESPOND;
            end else begin
               state_d = ST_READ_WAIT;
            end
         end
         ST_READ_WAIT: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = i_Rf_Read_Data;
            state_d     = ST_RESPOND;
         end
         ST_RESPOND: begin
            halt_d  = i_Hold_Halt;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign dbg_owns_rf_c = (state_q == ST_ACCESS) || (state_q == ST_READ_WAIT);

`ifdef DEBUG_REG_X0_GUARD_EN
   assign dbg_we_c = (state_q == ST_ACCESS) && wr_q && (addr_q != '0);
`else
   assign dbg_we_c = (state_q == ST_ACCESS) && wr_q;
`endif

   // Register-file port mux: CPU pass-through except while the debugger owns the ports.
   always_comb begin
      o_Rf_Write_Enable = i_Cpu_Reg_Write_Enable;
      o_Rf_Write_Addr   = i_Cpu_Reg_Write_Addr;
      o_Rf_Write_Data   = i_Cpu_Reg_Write_Data;
      o_Rf_Read_Addr    = i_Cpu_Reg_Read_Addr;
      if (dbg_owns_rf_c) begin
         o_Rf_Write_Enable = dbg_we_c;
         o_Rf_Write_Addr   = addr_q;
         o_Rf_Write_Data   = data_q;
         o_Rf_Read_Addr    = addr_q;
      end
   end

   assign dbg.o_Dbg_Req_Ready = (state_q == ST_IDLE);
   assign dbg.o_Dbg_Rsp_Valid = rsp_valid_q;
   assign dbg.o_Dbg_Rsp_Data  = rsp_data_q;
   assign dbg.o_Dbg_Rsp_Error = rsp_err_q;
   assign o_Halt_Request      = halt_q;

endmodule

// File: tb/tb_debug_regfile_access_ctrl.sv
// Bench for debug_regfile_access_ctrl: directed scenarios plus randomized requests vs a register-file model.
module tb_debug_regfile_access_ctrl;

   localparam int unsigned N = 16;
`ifdef DEBUG_REG_X0_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        i_Clock, i_Reset, i_Hold_Halt, o_Halt_Request, i_Pipeline_Flushed;
   logic        i_Cpu_Reg_Write_Enable;
   logic [4:0]  i_Cpu_Reg_Write_Addr, i_Cpu_Reg_Read_Addr;
   logic [31:0] i_Cpu_Reg_Write_Data;
   logic        o_Rf_Write_Enable;
   logic [4:0]  o_Rf_Write_Addr, o_Rf_Read_Addr;
   logic [31:0] o_Rf_Write_Data, i_Rf_Read_Data;

   debug_regfile_access_ctrl_if bus();

   debug_regfile_access_ctrl #(.FLUSH_TIMEOUT_CYCLES(N)) dut (
      .i_Clock(i_Clock), .i_Reset(i_Reset), .dbg(bus),
      .i_Hold_Halt(i_Hold_Halt), .o_Halt_Request(o_Halt_Request),
      .i_Pipeline_Flushed(i_Pipeline_Flushed),
      .i_Cpu_Reg_Write_Enable(i_Cpu_Reg_Write_Enable), .i_Cpu_Reg_Write_Addr(i_Cpu_Reg_Write_Addr),
      .i_Cpu_Reg_Write_Data(i_Cpu_Reg_Write_Data), .i_Cpu_Reg_Read_Addr(i_Cpu_Reg_Read_Addr),
      .o_Rf_Write_Enable(o_Rf_Write_Enable), .o_Rf_Write_Addr(o_Rf_Write_Addr),
      .o_Rf_Write_Data(o_Rf_Write_Data), .o_Rf_Read_Addr(o_Rf_Read_Addr),
      .i_Rf_Read_Data(i_Rf_Read_Data)
   );

   initial i_Clock = 1'b0;
   always #5 i_Clock = ~i_Clock;

   // Register file behind the DUT: registered read, one-cycle latency.
   logic [31:0] rf_mem [0:31];
   logic        mem_clr;
   always @(posedge i_Clock) begin
      if (mem_clr) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
      end else if (o_Rf_Write_Enable) begin
         rf_mem[o_Rf_Write_Addr] <= o_Rf_Write_Data;
      end
      i_Rf_Read_Data <= rf_mem[o_Rf_Read_Addr];
   end

   int          total, bad;
   logic [31:0] exp_rf [0:31];

   typedef struct {
      int          rsp_cyc;
      logic [31:0] rdat;
      logic        rerr;
      int          we_n;
      int          we_cyc;
      logic [4:0]  we_a;
      logic [31:0] we_d;
      logic [4:0]  ra_acc;
      logic [4:0]  ra_wait;
      logic        halt1;
      logic        halt_after;
      logic        rdy0;
      logic        busy_rdy;
   } obs_t;

   // Issues one request at cycle T (0) and records what happens in cycles T+1.. relative to it.
   // fd: first cycle after T with flush high; -1 = never.
   task automatic run_req(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                          input int fd, output obs_t o);
      logic [4:0] ra_hist [0:63];
      o.rsp_cyc = -1; o.rdat = 'x; o.rerr = 'x; o.we_n = 0; o.we_cyc = -1;
      o.we_a = 'x; o.we_d = 'x; o.ra_acc = 'x; o.ra_wait = 'x; o.halt1 = 'x;
      o.halt_after = 'x; o.busy_rdy = 1'b0;
      o.rdy0 = bus.o_Dbg_Req_Ready;
      bus.i_Dbg_Req_Valid = 1'b1;
      bus.i_Dbg_Req_Write = wr;
      bus.i_Dbg_Req_Addr  = addr;
      bus.i_Dbg_Req_Data  = data;
      i_Pipeline_Flushed  = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge i_Clock);
         ra_hist[k] = o_Rf_Read_Addr;
         if (k == 1) o.halt1 = o_Halt_Request;
         if (o.rsp_cyc >= 0 && k == o.rsp_cyc + 1) begin
            o.halt_after = o_Halt_Request;
            break;
         end
         if (bus.o_Dbg_Req_Ready) o.busy_rdy = 1'b1;
         if (o_Rf_Write_Enable) begin
            o.we_n++; o.we_cyc = k; o.we_a = o_Rf_Write_Addr; o.we_d = o_Rf_Write_Data;
         end
         if (bus.o_Dbg_Rsp_Valid && o.rsp_cyc < 0) begin
            o.rsp_cyc = k; o.rdat = bus.o_Dbg_Rsp_Data; o.rerr = bus.o_Dbg_Rsp_Error;
            if (k >= 2) o.ra_acc = ra_hist[k-2];
            o.ra_wait = ra_hist[k-1];
         end
         bus.i_Dbg_Req_Valid = 1'b0;
         i_Pipeline_Flushed  = (o.rsp_cyc < 0) && (fd >= 0) && (k >= fd);
      end
      i_Pipeline_Flushed = 1'b0;
   endtask

   task automatic test_reset();
      i_Reset = 1'b1; mem_clr = 1'b1;
      repeat (3) @(negedge i_Clock);
      mem_clr = 1'b0;
      total++; if (o_Halt_Request !== 1'b0) begin bad++; $display("FAIL reset_halt: got %b want 0", o_Halt_Request); end
      total++; if (bus.o_Dbg_Rsp_Valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.o_Dbg_Rsp_Valid); end
      total++; if (bus.o_Dbg_Rsp_Data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", bus.o_Dbg_Rsp_Data); end
      total++; if (bus.o_Dbg_Rsp_Error !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b want 0", bus.o_Dbg_Rsp_Error); end
      total++; if (bus.o_Dbg_Req_Ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.o_Dbg_Req_Ready); end
      i_Cpu_Reg_Write_Enable = 1'b1; i_Cpu_Reg_Write_Addr = 5'd4;
      i_Cpu_Reg_Write_Data = 32'hA5A5_0004; i_Cpu_Reg_Read_Addr = 5'd9;
      #1;
      total++;
      if ({o_Rf_Write_Enable, o_Rf_Write_Addr, o_Rf_Write_Data, o_Rf_Read_Addr} !== {1'b1, 5'd4, 32'hA5A5_0004, 5'd9}) begin
         bad++; $display("FAIL reset_passthru: got we=%b wa=%0d wd=%h ra=%0d want 1/4/a5a50004/9",
                         o_Rf_Write_Enable, o_Rf_Write_Addr, o_Rf_Write_Data, o_Rf_Read_Addr);
      end
      exp_rf[4] = 32'hA5A5_0004;
      @(negedge i_Clock);
      i_Cpu_Reg_Write_Enable = 1'b0; i_Reset = 1'b0;
      @(negedge i_Clock);
   endtask

   task automatic test_write();
      obs_t o;
      run_req(1'b1, 5'd5, 32'hDEADBEEF, 1, o);
      exp_rf[5] = 32'hDEADBEEF;
      total++; if (o.rdy0 !== 1'b1) begin bad++; $display("FAIL wr_ready_idle: got %b want 1", o.rdy0); end
      total++; if (o.halt1 !== 1'b1) begin bad++; $display("FAIL wr_halt_t1: got %b want 1", o.halt1); end
      total++; if (o.we_n != 1 || o.we_cyc != 2) begin bad++; $display("FAIL wr_we_pulse: got n=%0d cyc=%0d want 1/2", o.we_n, o.we_cyc); end
      total++; if (o.we_a !== 5'd5 || o.we_d !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_we_payload: got %0d/%h want 5/deadbeef", o.we_a, o.we_d); end
      total++; if (o.rsp_cyc != 3) begin bad++; $display("FAIL wr_rsp_cyc: got %0d want 3", o.rsp_cyc); end
      total++; if (o.rdat !== 32'h0 || o.rerr !== 1'b0) begin bad++; $display("FAIL wr_rsp: got %h/%b want 0/0", o.rdat, o.rerr); end
      total++; if (o.halt_after !== 1'b0) begin bad++; $display("FAIL wr_halt_t4: got %b want 0", o.halt_after); end
      total++; if (o.busy_rdy !== 1'b0) begin bad++; $display("FAIL wr_busy_ready: got %b want 0", o.busy_rdy); end
   endtask

   task automatic test_read();
      obs_t o;
      i_Cpu_Reg_Write_Enable = 1'b1; i_Cpu_Reg_Write_Addr = 5'd10; i_Cpu_Reg_Write_Data = 32'h12345678;
      @(negedge i_Clock);
      i_Cpu_Reg_Write_Enable = 1'b0;
      exp_rf[10] = 32'h12345678;
      run_req(1'b0, 5'd10, 32'h0, 7, o);
      total++; if (o.rsp_cyc != 10) begin bad++; $display("FAIL rd_rsp_cyc: got %0d want 10", o.rsp_cyc); end
      total++; if (o.rdat !== exp_rf[10] || o.rerr !== 1'b0) begin bad++; $display("FAIL rd_data: got %h/%b want %h/0", o.rdat, o.rerr, exp_rf[10]); end
      total++; if (o.ra_acc !== 5'd10 || o.ra_wait !== 5'd10) begin bad++; $display("FAIL rd_addr: got %0d/%0d want 10/10", o.ra_acc, o.ra_wait); end
      total++; if (o.we_n != 0) begin bad++; $display("FAIL rd_no_we: got %0d want 0", o.we_n); end
   endtask

   task automatic test_timeout();
      obs_t o;
      run_req(1'b1, 5'd9, 32'hCAFEF00D, -1, o);
      total++; if (o.rsp_cyc != int'(N) + 1) begin bad++; $display("FAIL to_rsp_cyc: got %0d want %0d", o.rsp_cyc, N + 1); end
      total++; if (o.rerr !== 1'b1 || o.rdat !== 32'h0) begin bad++; $display("FAIL to_rsp: got err=%b data=%h want 1/0", o.rerr, o.rdat); end
      total++; if (o.we_n != 0) begin bad++; $display("FAIL to_no_we: got %0d want 0", o.we_n); end
      total++; if (o.halt_after !== 1'b0) begin bad++; $display("FAIL to_halt_release: got %b want 0", o.halt_after); end
      run_req(1'b0, 5'd9, 32'h0, 2, o);
      total++; if (o.rdat !== exp_rf[9]) begin bad++; $display("FAIL to_x9_untouched: got %h want %h", o.rdat, exp_rf[9]); end
   endtask

   task automatic test_hold_halt();
      obs_t o;
      i_Hold_Halt = 1'b1;
      run_req(1'b0, 5'd5, 32'h0, 3, o);
      total++; if (o.rsp_cyc != 6 || o.rdat !== exp_rf[5]) begin bad++; $display("FAIL hold_rsp: got cyc=%0d data=%h want 6/%h", o.rsp_cyc, o.rdat, exp_rf[5]); end
      total++; if (o.halt_after !== 1'b1) begin bad++; $display("FAIL hold_halt_kept: got %b want 1", o.halt_after); end
      repeat (3) @(negedge i_Clock);
      total++; if (o_Halt_Request !== 1'b1) begin bad++; $display("FAIL hold_halt_idle: got %b want 1", o_Halt_Request); end
      i_Cpu_Reg_Write_Enable = 1'b1; i_Cpu_Reg_Write_Addr = 5'd7;
      i_Cpu_Reg_Write_Data = 32'h0BADC0DE; i_Cpu_Reg_Read_Addr = 5'd12;
      #1;
      total++;
      if ({o_Rf_Write_Enable, o_Rf_Write_Addr, o_Rf_Write_Data, o_Rf_Read_Addr} !== {1'b1, 5'd7, 32'h0BADC0DE, 5'd12}) begin
         bad++; $display("FAIL hold_passthru: got we=%b wa=%0d wd=%h ra=%0d want 1/7/0badc0de/12",
                         o_Rf_Write_Enable, o_Rf_Write_Addr, o_Rf_Write_Data, o_Rf_Read_Addr);
      end
      exp_rf[7] = 32'h0BADC0DE;
      @(negedge i_Clock);
      i_Cpu_Reg_Write_Enable = 1'b0; i_Hold_Halt = 1'b0;
      @(negedge i_Clock);
      total++; if (o_Halt_Request !== 1'b0) begin bad++; $display("FAIL hold_halt_drop: got %b want 0", o_Halt_Request); end
   endtask

   task automatic test_reset_mid_access();
      obs_t o;
      int   viol;
      viol = 0;
      bus.i_Dbg_Req_Valid = 1'b1; bus.i_Dbg_Req_Write = 1'b1;
      bus.i_Dbg_Req_Addr = 5'd3; bus.i_Dbg_Req_Data = 32'h33333333;
      @(negedge i_Clock);
      bus.i_Dbg_Req_Valid = 1'b0; i_Pipeline_Flushed = 1'b1;
      @(negedge i_Clock);
      total++; if (o_Rf_Write_Enable !== 1'b1) begin bad++; $display("FAIL rst_access_we: got %b want 1", o_Rf_Write_Enable); end
      i_Reset = 1'b1;
      for (int k = 3; k <= 10; k++) begin
         @(negedge i_Clock);
         if (k == 3) begin
            total++; if (o_Halt_Request !== 1'b0) begin bad++; $display("FAIL rst_halt: got %b want 0", o_Halt_Request); end
         end
         if (o_Rf_Write_Enable !== 1'b0 || bus.o_Dbg_Rsp_Valid !== 1'b0) viol++;
         i_Reset = 1'b0; i_Pipeline_Flushed = 1'b0;
      end
      total++; if (viol != 0) begin bad++; $display("FAIL rst_no_we_rsp: got %0d bad cycles want 0", viol); end
      run_req(1'b1, 5'd3, 32'h3C3C3C3C, 2, o);
      exp_rf[3] = 32'h3C3C3C3C;
      total++; if (o.rsp_cyc != 4 || o.we_n != 1 || o.rerr !== 1'b0) begin bad++; $display("FAIL rst_next_wr: got cyc=%0d we=%0d err=%b want 4/1/0", o.rsp_cyc, o.we_n, o.rerr); end
      run_req(1'b0, 5'd3, 32'h0, 1, o);
      total++; if (o.rdat !== exp_rf[3]) begin bad++; $display("FAIL rst_next_rd: got %h want %h", o.rdat, exp_rf[3]); end
   endtask

   task automatic test_x0();
      obs_t o;
      int   exp_we;
      exp_we = GUARD ? 0 : 1;
      run_req(1'b1, 5'd0, 32'hFFFFFFFF, 1, o);
      if (exp_we != 0) exp_rf[0] = 32'hFFFFFFFF;
      total++; if (o.we_n != exp_we) begin bad++; $display("FAIL x0_we: got %0d want %0d", o.we_n, exp_we); end
      total++; if (o.we_n != 0 && o.we_a !== 5'd0) begin bad++; $display("FAIL x0_we_addr: got %0d want 0", o.we_a); end
      total++; if (o.rsp_cyc != 3 || o.rerr !== 1'b0) begin bad++; $display("FAIL x0_rsp: got cyc=%0d err=%b want 3/0", o.rsp_cyc, o.rerr); end
      run_req(1'b0, 5'd0, 32'h0, 1, o);
      total++; if (o.rdat !== exp_rf[0]) begin bad++; $display("FAIL x0_readback: got %h want %h", o.rdat, exp_rf[0]); end
   endtask

   task automatic test_random();
      obs_t        o;
      logic        wr, hold, tmo;
      logic [4:0]  addr;
      logic [31:0] data, exp_dat;
      int          fd, exp_cyc, exp_we;
      for (int it = 0; it < 40; it++) begin
         wr   = 1'($urandom_range(0, 1));
         addr = 5'($urandom_range(0, 31));
         data = $urandom;
         fd   = int'($urandom_range(1, 20));
         hold = ($urandom_range(0, 3) == 0);
         i_Hold_Halt = hold;
         tmo     = (fd > int'(N));
         exp_cyc = tmo ? int'(N) + 1 : fd + (wr ? 2 : 3);
         exp_we  = (!tmo && wr && !(GUARD && addr == 5'd0)) ? 1 : 0;
         exp_dat = (!tmo && !wr) ? exp_rf[addr] : 32'h0;
         run_req(wr, addr, data, fd, o);
         if (exp_we != 0) exp_rf[addr] = data;
         total++; if (o.rsp_cyc != exp_cyc) begin bad++; $display("FAIL rnd%0d_cyc: got %0d want %0d", it, o.rsp_cyc, exp_cyc); end
         total++; if (o.rdat !== exp_dat || o.rerr !== tmo) begin bad++; $display("FAIL rnd%0d_rsp: got %h/%b want %h/%b", it, o.rdat, o.rerr, exp_dat, tmo); end
         total++; if (o.we_n != exp_we) begin bad++; $display("FAIL rnd%0d_we: got %0d want %0d", it, o.we_n, exp_we); end
         total++; if (o.we_n != 0 && (o.we_a !== addr || o.we_d !== data)) begin bad++; $display("FAIL rnd%0d_we_payload: got %0d/%h want %0d/%h", it, o.we_a, o.we_d, addr, data); end
         total++; if (o.halt_after !== hold || o.busy_rdy !== 1'b0) begin bad++; $display("FAIL rnd%0d_halt_rdy: got %b/%b want %b/0", it, o.halt_after, o.busy_rdy, hold); end
      end
      i_Hold_Halt = 1'b0;
      @(negedge i_Clock);
   endtask

   initial begin
      total = 0; bad = 0;
      for (int i = 0; i < 32; i++) exp_rf[i] = '0;
      bus.i_Dbg_Req_Valid = 1'b0; bus.i_Dbg_Req_Write = 1'b0;
      bus.i_Dbg_Req_Addr = '0; bus.i_Dbg_Req_Data = '0;
      i_Hold_Halt = 1'b0; i_Pipeline_Flushed = 1'b0;
      i_Cpu_Reg_Write_Enable = 1'b0; i_Cpu_Reg_Write_Addr = '0;
      i_Cpu_Reg_Write_Data = '0; i_Cpu_Reg_Read_Addr = '0;
      i_Reset = 1'b1; mem_clr = 1'b1;
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_hold_halt();
      test_reset_mid_access();
      test_x0();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
